rom_fetch_arbiter: RTL and testbench

- Shares the single-port 1024x12 pattern ROM between two requesters.
- Port 0 is the HDMI pixel fetch (real-time, priority). Port 1 is the overlay/sprite fetch (background).
- Issues at most one ROM read per clock, tracks in-flight reads through the ROM's fixed read latency, and routes each returned word to its originator with a valid strobe.
- A starvation guard guarantees port 1 forward progress.

---
 rtl/rom_fetch_arbiter_if.sv | 27 ++
 rtl/rom_fetch_arbiter.sv | 120 ++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_arbiter_if.sv
// Requester-side bus of the pattern ROM arbiter: two read ports with
// request/grant handshake and a valid-qualified return path each.
interface rom_fetch_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, addr0, req1, addr1,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
    );

    modport slave (
        input  req0, addr0, req1, addr1,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Shares one single-port pattern ROM between the real-time pixel fetch
// (port 0, priority) and the background overlay fetch (port 1).
module rom_fetch_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 12,
    parameter int READ_LAT = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    rom_fetch_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]   rom_ad,
    output logic                rom_ce,
    output logic                rom_oce,
    output logic                rom_wre,
    output logic                rom_reset,
    input  logic [DATA_W-1:0]   rom_dout
);
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [7:0]          wait_cnt;
    logic                gnt0;
    logic                gnt1;
    logic [READ_LAT-1:0] tag_valid;
    logic [READ_LAT-1:0] tag_port;
    logic                ret_valid;
    logic                ret_port;
    logic                rvalid0;
    logic                rvalid1;
    logic [DATA_W-1:0]   rdata0;
    logic [DATA_W-1:0]   rdata1;

    // Port 1 wins only when port 0 is idle or port 1 has lost MAX_WAIT times in a row.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (bus.req1 && (!bus.req0 || wait_cnt == WAIT_MAX)) begin
                gnt1 = 1'b1;
            end else if (bus.req0) begin
                gnt0 = 1'b1;
            end
        end
    end

    always_comb begin
        rom_ad = '0;
        if (gnt1) begin
            rom_ad = bus.addr1;
        end else if (gnt0) begin
            rom_ad = bus.addr0;
        end
    end

    assign rom_ce    = gnt0 | gnt1;
    assign rom_oce   = 1'b1;
    assign rom_wre   = 1'b0;
    assign rom_reset = reset;

    always_ff @(posedge clk) begin
        if (reset || gnt1 || !bus.req1) begin
            wait_cnt <= '0;
        end else if (gnt0 && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Tag shift register mirrors the ROM read latency; bit 0 is loaded at accept.
    generate
        if (READ_LAT == 1) begin : g_tag_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_valid <= '0;
                    tag_port  <= '0;
                end else begin
                    tag_valid <= rom_ce;
                    tag_port  <= gnt1;
                end
            end
        end else begin : g_tag_latn
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_valid <= '0;
                    tag_port  <= '0;
                end else begin
                    tag_valid <= {tag_valid[READ_LAT-2:0], rom_ce};
                    tag_port  <= {tag_port[READ_LAT-2:0], gnt1};
                end
            end
        end
    endgenerate

    assign ret_valid = tag_valid[READ_LAT-1];
    assign ret_port  = tag_port[READ_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= ret_valid & ~ret_port;
            rvalid1 <= ret_valid & ret_port;
            if (ret_valid && !ret_port) begin
                rdata0 <= rom_dout;
            end
            if (ret_valid && ret_port) begin
                rdata1 <= rom_dout;
            end
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0;
    assign bus.rvalid1 = rvalid1;
    assign bus.rdata0  = rdata0;
    assign bus.rdata1  = rdata1;
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: three instances (READ_LAT 1/3/2), a ROM model,
// and a per-instance scoreboard of expected returns filled at each accept.
module tb_rom_fetch_arbiter;
    typedef struct {
        bit          port;
        logic [11:0] data;
        int          due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst   [3];
    logic       rq0   [3];
    logic       rq1   [3];
    logic [9:0] ad0   [3];
    logic [9:0] ad1   [3];

    logic        o_gnt0 [3];
    logic        o_gnt1 [3];
    logic        o_rv0  [3];
    logic        o_rv1  [3];
    logic [11:0] o_rd0  [3];
    logic [11:0] o_rd1  [3];
    logic [9:0]  o_ad   [3];
    logic        o_ce   [3];
    logic        o_oce  [3];
    logic        o_wre  [3];
    logic        o_rrst [3];

    exp_t        sbq [3][$];
    int          wcnt  [3];
    logic [11:0] last0 [3];
    logic [11:0] last1 [3];
    int          rvc0  [3];
    int          rvc1  [3];
    int          cec   [3];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 2;
    endfunction

    function automatic int mw_of(input int i);
        return (i == 0) ? 3 : 15;
    endfunction

    function automatic logic [11:0] rom_word(input logic [9:0] a);
        if (a < 10'd4) return 12'h00F;
        return {2'b00, a} * 12'd37 + 12'h3C1;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : g_inst
            localparam int L  = (g == 0) ? 1 : (g == 1) ? 3 : 2;
            localparam int MW = (g == 0) ? 3 : 15;

            rom_fetch_arbiter_if #(.ADDR_W(10), .DATA_W(12)) bus ();
            logic [11:0] rom_dout;
            logic [11:0] rpipe [L];

            assign bus.req0  = rq0[g];
            assign bus.addr0 = ad0[g];
            assign bus.req1  = rq1[g];
            assign bus.addr1 = ad1[g];
            assign o_gnt0[g] = bus.gnt0;
            assign o_gnt1[g] = bus.gnt1;
            assign o_rv0[g]  = bus.rvalid0;
            assign o_rv1[g]  = bus.rvalid1;
            assign o_rd0[g]  = bus.rdata0;
            assign o_rd1[g]  = bus.rdata1;
            assign rom_dout  = rpipe[L-1];

            rom_fetch_arbiter #(
                .ADDR_W(10), .DATA_W(12), .READ_LAT(L), .MAX_WAIT(MW)
            ) dut (
                .clk       (clk),
                .reset     (rst[g]),
                .bus       (bus),
                .rom_ad    (o_ad[g]),
                .rom_ce    (o_ce[g]),
                .rom_oce   (o_oce[g]),
                .rom_wre   (o_wre[g]),
                .rom_reset (o_rrst[g]),
                .rom_dout  (rom_dout)
            );

            // ROM model: address registered when ce is high, then READ_LAT-1 output stages.
            always @(posedge clk) begin
                if (o_ce[g]) rpipe[0] <= rom_word(o_ad[g]);
                for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
            end
        end
    endgenerate

    // Per-cycle reference: same-cycle grants, scoreboard pushes and return checks.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            exp_t f;
            exp_t n;
            bit   hv;
            bit   e0;
            bit   e1;
            hv = (sbq[i].size() > 0) && (sbq[i][0].due == cyc);
            if (hv) f = sbq[i][0];
            chk("rvalid0", i, o_rv0[i], hv && !f.port);
            chk("rvalid1", i, o_rv1[i], hv && f.port);
            if (hv && !f.port) last0[i] = f.data;
            if (hv && f.port) last1[i] = f.data;
            chk("rdata0", i, o_rd0[i], last0[i]);
            chk("rdata1", i, o_rd1[i], last1[i]);
            if (hv) void'(sbq[i].pop_front());
            chk("rom_oce", i, o_oce[i], 1);
            chk("rom_wre", i, o_wre[i], 0);
            chk("rom_reset", i, o_rrst[i], rst[i]);
            if (rst[i]) begin
                chk("gnt0_rst", i, o_gnt0[i], 0);
                chk("gnt1_rst", i, o_gnt1[i], 0);
                chk("ce_rst", i, o_ce[i], 0);
                sbq[i].delete();
                wcnt[i]  = 0;
                last0[i] = '0;
                last1[i] = '0;
            end else begin
                e1 = rq1[i] && (!rq0[i] || wcnt[i] == mw_of(i));
                e0 = rq0[i] && !e1;
                chk("gnt0", i, o_gnt0[i], e0);
                chk("gnt1", i, o_gnt1[i], e1);
                chk("rom_ce", i, o_ce[i], e0 | e1);
                chk("rom_ad", i, o_ad[i], e1 ? ad1[i] : e0 ? ad0[i] : 10'd0);
                if (e0 || e1) begin
                    n.port = e1;
                    n.data = rom_word(e1 ? ad1[i] : ad0[i]);
                    n.due  = cyc + lat_of(i) + 1;
                    sbq[i].push_back(n);
                end
                if (e1 || !rq1[i]) wcnt[i] = 0;
                else if (e0 && wcnt[i] < mw_of(i)) wcnt[i]++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (o_rv0[i] === 1'b1) rvc0[i]++;
            if (o_rv1[i] === 1'b1) rvc1[i]++;
            if (o_ce[i] === 1'b1) cec[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 3; i++) begin
            rvc0[i] = 0;
            rvc1[i] = 0;
            cec[i]  = 0;
        end
    endtask

    task automatic drain(input int i);
        for (int t = 0; t < 10 && sbq[i].size() > 0; t++) tick();
        chk("drain", i, sbq[i].size(), 0);
    endtask

    initial begin
        int ng1;
        logic g0;
        logic g1;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; rq0[i] = 1'b0; rq1[i] = 1'b0;
            ad0[i] = '0;   ad1[i] = '0;
            wcnt[i] = 0;   last0[i] = '0; last1[i] = '0;
        end
        clr_counts();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        tick();

        // Port 0 alone, words 0..3 back to back
        clr_counts();
        for (int n = 0; n < 4; n++) begin
            rq0[0] = 1'b1;
            ad0[0] = 10'(n);
            tick();
        end
        rq0[0] = 1'b0;
        drain(0);
        chk("t1_rvalid0_count", 0, rvc0[0], 4);
        chk("t1_rvalid1_count", 0, rvc1[0], 0);
        chk("t1_rdata0", 0, o_rd0[0], 12'h00F);

        // Port 1 alone
        clr_counts();
        rq1[0] = 1'b1;
        ad1[0] = 10'h0A0;
        tick();
        rq1[0] = 1'b0;
        drain(0);
        chk("t2_rvalid1_count", 0, rvc1[0], 1);
        chk("t2_rvalid0_count", 0, rvc0[0], 0);
        chk("t2_rdata1", 0, o_rd1[0], rom_word(10'h0A0));

        // Both continuously with MAX_WAIT=3: every fourth grant goes to port 1
        clr_counts();
        ng1 = 0;
        rq0[0] = 1'b1; ad0[0] = 10'h100;
        rq1[0] = 1'b1; ad1[0] = 10'h200;
        #0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            g0 = o_gnt0[0];
            g1 = o_gnt1[0];
            if (g1 === 1'b1) ng1++;
            if (o_rv0[0] === 1'b1) rvc0[0]++;
            if (o_rv1[0] === 1'b1) rvc1[0]++;
            @(posedge clk);
            #1;
            if (g0 === 1'b1) ad0[0] = ad0[0] + 10'd1;
            if (g1 === 1'b1) ad1[0] = ad1[0] + 10'd1;
        end
        rq0[0] = 1'b0;
        rq1[0] = 1'b0;
        drain(0);
        chk("t3_gnt1_count", 0, ng1, 4);
        chk("t3_rvalid_total", 0, rvc0[0] + rvc1[0], 16);

        // Alternating ports with READ_LAT=3
        clr_counts();
        for (int n = 0; n < 12; n++) begin
            rq0[1] = (n % 2 == 0);
            rq1[1] = (n % 2 == 1);
            ad0[1] = 10'h300 + 10'(n);
            ad1[1] = 10'h380 + 10'(n);
            tick();
        end
        rq0[1] = 1'b0;
        rq1[1] = 1'b0;
        drain(1);
        chk("t4_rvalid0_count", 1, rvc0[1], 6);
        chk("t4_rvalid1_count", 1, rvc1[1], 6);

        // Reset right after two accepts with READ_LAT=2
        clr_counts();
        rq0[2] = 1'b1;
        ad0[2] = 10'h010; tick();
        ad0[2] = 10'h011; tick();
        rst[2] = 1'b1;
        ad0[2] = 10'h012; tick();
        rst[2] = 1'b0;
        tick();
        rq0[2] = 1'b0;
        drain(2);
        chk("t5_rvalid0_count", 2, rvc0[2], 1);
        chk("t5_rdata0", 2, o_rd0[2], rom_word(10'h012));

        // Idle: no ROM activity, no returns, data holds
        clr_counts();
        repeat (10) tick();
        chk("t6_ce_count", 0, cec[0], 0);
        chk("t6_rvalid_count", 0, rvc0[0] + rvc1[0], 0);
        chk("t6_rdata1_hold", 0, o_rd1[0], last1[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
